// File: rtl/log_adder_pipe.sv
// rtl/log_adder_pipe.sv - multi-lane two-stage log-domain adder with valid/ready flow control
// Each lane adds {log, fraction} pairs; a fraction carry increments the log sum.
module log_adder_pipe #(
    parameter int LOG2_WIDTH = 4,
    parameter int WIDTH      = 2**LOG2_WIDTH,
    parameter int LANES      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*(WIDTH-1)-1:0]      A,
    input  logic [LANES*(WIDTH-1)-1:0]      B,
    input  logic [LANES*LOG2_WIDTH-1:0]     log_a,
    input  logic [LANES*LOG2_WIDTH-1:0]     log_b,
    input  logic [LANES-1:0]                zero_a,
    input  logic [LANES-1:0]                zero_b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*(WIDTH-1)-1:0]      ops_sum,
    output logic [LANES*(LOG2_WIDTH+1)-1:0] log_sum,
    output logic [LANES-1:0]                out_zero
);

    localparam int FW = WIDTH - 1;
    localparam int LW = LOG2_WIDTH;
    localparam int SW = LOG2_WIDTH + 1;

    logic                  s1_valid;
    logic [LANES*FW-1:0]   s1_a;
    logic [LANES*FW-1:0]   s1_b;
    logic [LANES*LW-1:0]   s1_log_a;
    logic [LANES*LW-1:0]   s1_log_b;
    logic [LANES-1:0]      s1_zero_a;
    logic [LANES-1:0]      s1_zero_b;

    logic                  s1_load;
    logic                  s2_load;

    logic [LANES*FW-1:0]   res_ops;
    logic [LANES*SW-1:0]   res_log;
    logic [LANES-1:0]      res_zero;

    // out_valid is the S2 valid flop itself.
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~rst & (~s1_valid | s2_load);
    assign s1_load  = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_log_a  <= '0;
            s1_log_b  <= '0;
            s1_zero_a <= '0;
            s1_zero_b <= '0;
        end else begin
            s1_valid <= s1_load | (s1_valid & ~s2_load);
            if (s1_load) begin
                s1_a      <= A;
                s1_b      <= B;
                s1_log_a  <= log_a;
                s1_log_b  <= log_b;
                s1_zero_a <= zero_a;
                s1_zero_b <= zero_b;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LW+FW:0] sum;
        logic           zero;

        assign zero = s1_zero_a[i] | s1_zero_b[i];
        // Extra top bit keeps the log carry; the fraction carry lands in bit FW.
        assign sum  = {1'b0, s1_log_a[i*LW +: LW], s1_a[i*FW +: FW]}
                    + {1'b0, s1_log_b[i*LW +: LW], s1_b[i*FW +: FW]};

        assign res_ops[i*FW +: FW] = zero ? '0 : sum[FW-1:0];
        assign res_log[i*SW +: SW] = zero ? '0 : sum[LW+FW:FW];
        assign res_zero[i]         = zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ops_sum   <= '0;
            log_sum   <= '0;
            out_zero  <= '0;
        end else begin
            out_valid <= s2_load | (out_valid & ~out_ready);
            if (s2_load) begin
                ops_sum  <= res_ops;
                log_sum  <= res_log;
                out_zero <= res_zero;
            end
        end
    end

endmodule

// File: tb/tb_log_adder_pipe.sv
// tb/tb_log_adder_pipe.sv - self-checking bench for log_adder_pipe
// Directed scenarios plus randomized traffic against an arithmetic scoreboard.
module tb_log_adder_pipe;

    localparam int LOG2_WIDTH = 4;
    localparam int WIDTH      = 16;
    localparam int LANES      = 4;
    localparam int FW         = WIDTH - 1;
    localparam int SW         = LOG2_WIDTH + 1;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            in_valid;
    logic                            in_ready;
    logic [LANES*FW-1:0]             A;
    logic [LANES*FW-1:0]             B;
    logic [LANES*LOG2_WIDTH-1:0]     log_a;
    logic [LANES*LOG2_WIDTH-1:0]     log_b;
    logic [LANES-1:0]                zero_a;
    logic [LANES-1:0]                zero_b;
    logic                            out_valid;
    logic                            out_ready;
    logic [LANES*FW-1:0]             ops_sum;
    logic [LANES*SW-1:0]             log_sum;
    logic [LANES-1:0]                out_zero;

    int checks = 0;
    int errors = 0;

    logic [LANES*FW-1:0] q_ops[$];
    logic [LANES*SW-1:0] q_log[$];
    logic [LANES-1:0]    q_zero[$];

    logic last_acc;
    logic last_del;

    log_adder_pipe #(
        .LOG2_WIDTH(LOG2_WIDTH),
        .WIDTH     (WIDTH),
        .LANES     (LANES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .log_a    (log_a),
        .log_b    (log_b),
        .zero_a   (zero_a),
        .zero_b   (zero_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ops_sum  (ops_sum),
        .log_sum  (log_sum),
        .out_zero (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the product exponent is the plain integer sum of log*2^FW + fraction.
    task automatic push_model();
        logic [LANES*FW-1:0] e_ops;
        logic [LANES*SW-1:0] e_log;
        logic [LANES-1:0]    e_zero;
        int total;
        for (int i = 0; i < LANES; i++) begin
            e_zero[i] = zero_a[i] | zero_b[i];
            total = int'(log_a[i*LOG2_WIDTH +: LOG2_WIDTH]) * 32768 + int'(A[i*FW +: FW])
                  + int'(log_b[i*LOG2_WIDTH +: LOG2_WIDTH]) * 32768 + int'(B[i*FW +: FW]);
            if (e_zero[i]) total = 0;
            e_ops[i*FW +: FW] = 15'(total % 32768);
            e_log[i*SW +: SW] = 5'(total / 32768);
        end
        q_ops.push_back(e_ops);
        q_log.push_back(e_log);
        q_zero.push_back(e_zero);
    endtask

    task automatic rand_beat();
        for (int i = 0; i < LANES; i++) begin
            A[i*FW +: FW]                 = 15'($urandom);
            B[i*FW +: FW]                 = 15'($urandom);
            log_a[i*LOG2_WIDTH +: LOG2_WIDTH] = 4'($urandom);
            log_b[i*LOG2_WIDTH +: LOG2_WIDTH] = 4'($urandom);
            zero_a[i]                     = ($urandom_range(7) == 0);
            zero_b[i]                     = ($urandom_range(7) == 0);
        end
    endtask

    task automatic clear_beat();
        A = '0; B = '0; log_a = '0; log_b = '0; zero_a = '0; zero_b = '0;
    endtask

    // Called at a negedge with data already set; returns at the next negedge.
    task automatic step(input logic v, input logic r);
        in_valid  = v;
        out_ready = r;
        #1;
        last_acc = in_valid & in_ready;
        last_del = out_valid & out_ready;
        if (last_del) begin
            check("sb_nonempty", 64'(q_ops.size() != 0), 64'd1);
            if (q_ops.size() != 0) begin
                check("sb_ops", 64'(ops_sum), 64'(q_ops[0]));
                check("sb_log", 64'(log_sum), 64'(q_log[0]));
                check("sb_zero", 64'(out_zero), 64'(q_zero[0]));
                void'(q_ops.pop_front());
                void'(q_log.pop_front());
                void'(q_zero.pop_front());
            end
        end
        if (last_acc) push_model();
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int sent;
        int cyc;
        logic [LANES*FW-1:0] held_ops;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        clear_beat();
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_ops", 64'(ops_sum), 64'd0);
        check("rst_log", 64'(log_sum), 64'd0);
        check("rst_zero", 64'(out_zero), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Carry into log, with latency check
        clear_beat();
        log_a[3:0] = 4'd3; A[14:0] = 15'h4000;
        log_b[3:0] = 4'd2; B[14:0] = 15'h4000;
        step(1'b1, 1'b1);
        check("t1_accept", 64'(last_acc), 64'd1);
        check("t1_not_yet", 64'(out_valid), 64'd0);
        step(1'b0, 1'b1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_log0", 64'(log_sum[4:0]), 64'd6);
        check("t1_ops0", 64'(ops_sum[14:0]), 64'h0000);
        check("t1_zero0", 64'(out_zero[0]), 64'd0);
        step(1'b0, 1'b1);

        // Maximum operands then no-carry beat, back to back
        for (int i = 0; i < LANES; i++) begin
            A[i*FW +: FW] = 15'h7FFF; B[i*FW +: FW] = 15'h7FFF;
            log_a[i*4 +: 4] = 4'd15;  log_b[i*4 +: 4] = 4'd15;
        end
        zero_a = '0; zero_b = '0;
        step(1'b1, 1'b1);
        clear_beat();
        log_a[3:0] = 4'd1; A[14:0] = 15'h0001;
        log_b[3:0] = 4'd1; B[14:0] = 15'h0002;
        step(1'b1, 1'b1);
        for (int i = 0; i < LANES; i++) begin
            check("t2_max_log", 64'(log_sum[i*SW +: SW]), 64'd31);
            check("t2_max_ops", 64'(ops_sum[i*FW +: FW]), 64'h7FFE);
        end
        step(1'b0, 1'b1);
        check("t2_nc_log", 64'(log_sum[4:0]), 64'd2);
        check("t2_nc_ops", 64'(ops_sum[14:0]), 64'h0003);
        step(1'b0, 1'b1);

        // Zero flag on lane 2
        clear_beat();
        log_a[8 +: 4] = 4'd9; A[30 +: 15] = 15'h1234; zero_b[2] = 1'b1;
        log_b[8 +: 4] = 4'd7; B[30 +: 15] = 15'h0F0F;
        log_a[3:0] = 4'd2; A[14:0] = 15'd5;
        log_b[3:0] = 4'd3; B[14:0] = 15'd7;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("t3_zero2", 64'(out_zero[2]), 64'd1);
        check("t3_log2", 64'(log_sum[10 +: 5]), 64'd0);
        check("t3_ops2", 64'(ops_sum[30 +: 15]), 64'd0);
        check("t3_zero0", 64'(out_zero[0]), 64'd0);
        check("t3_log0", 64'(log_sum[4:0]), 64'd5);
        check("t3_ops0", 64'(ops_sum[14:0]), 64'd12);
        step(1'b0, 1'b1);

        // Back-pressure: only two beats absorbed, outputs hold beat 1
        idx = 0;
        rand_beat();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            if (last_acc) begin
                idx++;
                rand_beat();
            end
        end
        check("t4_absorbed", 64'(idx), 64'd2);
        check("t4_in_ready", 64'(in_ready), 64'd0);
        check("t4_out_valid", 64'(out_valid), 64'd1);
        check("t4_hold_ops", 64'(ops_sum), 64'(q_ops[0]));
        held_ops = ops_sum;
        step(1'b1, 1'b0);
        check("t4_stable", 64'(ops_sum), 64'(held_ops));
        for (int k = 0; k < 5; k++) begin
            step(idx < 5, 1'b1);
            check("t4_deliver", 64'(last_del), 64'd1);
            if (last_acc) begin
                idx++;
                if (idx < 5) rand_beat();
            end
        end
        check("t4_all_sent", 64'(idx), 64'd5);
        check("t4_drained", 64'(q_ops.size()), 64'd0);

        // Randomized traffic
        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || q_ops.size() != 0) && cyc < 60000) begin
            rand_beat();
            step((sent < 10000) && ($urandom_range(3) != 0), $urandom_range(3) != 0);
            if (last_acc) sent++;
            cyc++;
        end
        check("t5_sent", 64'(sent), 64'd10000);
        check("t5_drained", 64'(q_ops.size()), 64'd0);

        // Reset with two beats in flight
        rand_beat();
        step(1'b1, 1'b0);
        rand_beat();
        step(1'b1, 1'b0);
        check("t6_full", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd0);
        check("t6_rst_ops", 64'(ops_sum), 64'd0);
        check("t6_rst_log", 64'(log_sum), 64'd0);
        check("t6_rst_zero", 64'(out_zero), 64'd0);
        q_ops.delete(); q_log.delete(); q_zero.delete();
        @(negedge clk);
        rst = 1'b0;
        rand_beat();
        step(1'b1, 1'b1);
        check("t6_accept", 64'(last_acc), 64'd1);
        check("t6_not_yet", 64'(out_valid), 64'd0);
        step(1'b0, 1'b1);
        check("t6_valid", 64'(out_valid), 64'd1);
        step(1'b0, 1'b1);
        check("t6_delivered", 64'(last_del), 64'd1);
        step(1'b0, 1'b1);
        check("t6_no_stale", 64'(out_valid), 64'd0);
        check("t6_drained", 64'(q_ops.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/log_adder_pipe.md
# log_adder_pipe

Multi-lane, pipelined successor to the single-lane combinational log-domain adder used in the approximate (Mitchell-style) multiplier datapath. Each lane forms `{log_a, A} + {log_b, B}` and splits the result into a fractional sum and a carried-in log sum, as the product-exponent stage of the log multiplier requires. The block adds four things:

- a `LANES`-wide vector interface;
- a two-stage registered pipeline;
- valid/ready flow control with full back-pressure;
- per-lane zero-operand flags that force a zero product.

It sits between the per-operand priority encoders and the antilog/shift stage of each processing element.

## Interface

Parameters:
- `LOG2_WIDTH`, default 4: log2 of operand width.
- `WIDTH`, default `2**LOG2_WIDTH`: operand width. The fraction field is `WIDTH-1` bits.
- `LANES`, default 4: number of independent lanes, all sharing one handshake.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `A`, `B`  in  `LANES*(WIDTH-1)`  fraction fields; lane i is bits `[i*(WIDTH-1) +: WIDTH-1]`.
- `log_a`, `log_b`  in  `LANES*LOG2_WIDTH`  log fields; lane i is bits `[i*LOG2_WIDTH +: LOG2_WIDTH]`.
- `zero_a`, `zero_b`  in  `LANES`  lane operand is zero.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the output beat.
- `ops_sum`  out  `LANES*(WIDTH-1)`  per-lane fractional sum.
- `log_sum`  out  `LANES*(LOG2_WIDTH+1)`  per-lane log sum, including the carry.
- `out_zero`  out  `LANES`  per-lane zero product.

## Operation

**Per-lane arithmetic**
- `sum[LOG2_WIDTH+WIDTH-1:0] = {log_a_i, A_i} + {log_b_i, B_i}`, unsigned, with no overflow possible.
- `ops_sum_i = sum[WIDTH-2:0]`.
- `log_sum_i = sum[LOG2_WIDTH+WIDTH-1:WIDTH-1]`. A carry out of the fraction increments the log.

**Zero handling**
- `out_zero_i = zero_a_i | zero_b_i`.
- When `out_zero_i` is set, `ops_sum_i` and `log_sum_i` are forced to 0. Operand values in that lane are ignored.

**Pipeline stages**
- Stage 1 (S1) registers the raw lane inputs plus `s1_valid`.
- Stage 2 (S2) registers the computed lane results plus `s2_valid`. S2 drives the outputs directly from flops.

**Flow control**
- `s2_load = s1_valid & (~s2_valid | out_ready)`.
- `s1_load = in_valid & in_ready`.
- `in_ready = ~rst & (~s1_valid | s2_load)`. This is combinational, so a full pipeline still accepts a beat in the cycle the output is consumed.
- `s1_valid` next value: `s1_load | (s1_valid & ~s2_load)`.
- `s2_valid` next value: `s2_load | (s2_valid & ~out_ready)`.
- S1 and S2 data registers update only on their load strobe. Otherwise they hold.
- A beat is transferred on any edge where valid & ready.

**Ordering and lanes**
- Beats leave in acceptance order. No beat is dropped or duplicated.
- All lanes move together. Lanes never interact.

## Timing

**Reset**
- On `rst` high, immediately and asynchronously: `s1_valid`, `s2_valid`, `out_valid` go to 0.
- `ops_sum`, `log_sum`, `out_zero` go to 0, and all S1 data goes to 0.
- `in_ready` is 0 while `rst` is high.

**Latency and throughput**
- A beat accepted at edge N appears with `out_valid=1` after edge N+1, provided S2 is free. Latency is 2 cycles.
- Throughput is 1 beat/cycle when `out_ready` is held at 1.

**Back-pressure**
- With `out_ready=0`, the block absorbs at most 2 beats, then `in_ready` falls to 0.
- While `out_valid=1` and `out_ready=0`, the outputs hold stable.
- When `out_ready` rises with both stages full, S2 drains, S1 moves to S2, and a new beat is accepted, all in the same cycle.

**Reset mid-operation**
- Any in-flight beats are discarded.
- The first beat accepted after `rst` falls behaves as from an empty pipeline.

**Boundaries**
- With no input beat, `in_valid=0` leaves `s1_valid` falling after S1 drains.
- Outputs are never X after reset.

## Test plan

Defaults for all scenarios: `LOG2_WIDTH=4`, `WIDTH=16`, `LANES=4`.

1. **Carry into log.** Lane 0: `log_a=3`, `A=0x4000`, `log_b=2`, `B=0x4000`, `out_ready=1` -> two cycles later `log_sum=6`, `ops_sum=0x0000`, `out_zero=0`.
2. **Maximum operands.** All lanes `log=15`, fraction `0x7FFF` -> each lane `log_sum=31`, `ops_sum=0x7FFE`. No-carry case: `log_a=1`, `A=0x0001`, `log_b=1`, `B=0x0002` -> `log_sum=2`, `ops_sum=0x0003`.
3. **Zero flags.** Lane 2: `zero_b=1` with `log_a=9`, `A=0x1234` -> lane 2 outputs `out_zero=1`, `log_sum=0`, `ops_sum=0`. The other lanes are unaffected.
4. **Back-pressure.** Hold `out_ready=0` and stream beats 1..5 -> exactly beats 1 and 2 accepted, `in_ready=0` from then on, outputs stable at beat 1. Raise `out_ready` -> beats 1..5 delivered in order, one per cycle, with no loss or duplication.
5. **Random throughput.** Random `in_valid`/`out_ready` over 10k beats, checked against a scoreboard model -> all sums match and ordering is preserved.
6. **Reset mid-operation.** Assert `rst` with 2 beats in flight -> `out_valid`, `in_ready`, and all outputs go to 0 immediately. After deassert, the next beat emerges 2 cycles after acceptance, and the stale beats never appear.
